// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: register-file defaults, address-width helper and
// the soft-clear sweep state encoding.
// Revision: 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int RF_DW_DEF   = 32;
  localparam int RF_NREG_DEF = 32;

  // Ceiling log2, used to derive the register address width from NREG.
  function automatic int rf_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_SWEEP = 1'b1
  } rf_state_e;

endpackage
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_scoreboard
// One pending-write bit per register. Issue sets, write-back clears, a newer
// issue to the same register on the same edge wins. Per-port lookup reports
// an outstanding producer unless the write-back is landing this cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rf_scoreboard
  import cpu_pkg::*;
#(
  parameter int  NREG     = RF_NREG_DEF,
  parameter int  NRD      = 2,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = rf_clog2(NREG)
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              set_en_i,
  input  logic [AW-1:0]     set_addr_i,
  input  logic              clr_en_i,
  input  logic [AW-1:0]     clr_addr_i,
  input  logic              clr_all_i,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic [NRD-1:0]    rpend_o
);

  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;

  // Next pending vector: sweep start wipes everything, otherwise clear then set.
  always_comb begin
    pend_d = pend_q;
    if (clr_all_i) begin
      pend_d = '0;
    end else begin
      if (clr_en_i) pend_d[clr_addr_i] = 1'b0;
      if (set_en_i && !(ZERO_REG && (set_addr_i == '0))) pend_d[set_addr_i] = 1'b1;
    end
  end

  // Pending-bit register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rpend
    logic [AW-1:0] ra;
    logic          hit_wb;
    logic          is_zero;
    assign ra      = raddr_i[k*AW +: AW];
    assign hit_wb  = clr_en_i && (clr_addr_i == ra);
    assign is_zero = ZERO_REG && (ra == '0);
    assign rpend_o[k] = pend_q[ra] && !hit_wb && !is_zero;
  end

endmodule
`default_nettype wire

// File: rtl/rf_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_bank
// Parametrised GPR file: NRD combinational read ports with write-through
// bypass, pending-write scoreboard, multi-cycle soft-clear sweep, debug port.
// Revision: 1.0
// ---------------------------------------------------------------------------
module rf_bank
  import cpu_pkg::*;
#(
  parameter int  DW       = RF_DW_DEF,
  parameter int  NREG     = RF_NREG_DEF,
  parameter int  NRD      = 2,
  parameter bit  ZERO_REG = 1'b1,
  localparam int AW       = rf_clog2(NREG)
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DW-1:0]     wdata_i,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic [NRD*DW-1:0] rdata_o,
  output logic [NRD-1:0]    rpend_o,
  input  logic              iss_valid_i,
  input  logic [AW-1:0]     iss_addr_i,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  input  logic [AW-1:0]     dbg_sel_i,
  output logic [DW-1:0]     dbg_data_o
);

  localparam logic [AW-1:0] IDX_FIRST = ZERO_REG ? AW'(1) : '0;
  localparam logic [AW-1:0] IDX_LAST  = AW'(NREG - 1);

  rf_state_e     state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          wr_en;
  logic          swp_en;
  logic          clr_all;
  logic          idle;
  logic          byp_en;
  logic [DW-1:0] regs_q [NREG];

  assign idle       = (state_q == RF_IDLE);
  assign byp_en     = we_i && idle;
  assign clr_busy_o = (state_q == RF_SWEEP);

  // Sweep FSM next state, sweep index and storage write strobes.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
    swp_en  = 1'b0;
    clr_all = 1'b0;
    case (state_q)
      RF_IDLE: begin
        wr_en = we_i && !(ZERO_REG && (waddr_i == '0));
        if (clr_req_i) begin
          state_d = RF_SWEEP;
          idx_d   = IDX_FIRST;
          clr_all = 1'b1;
        end
      end
      RF_SWEEP: begin
        swp_en = 1'b1;
        if (idx_q == IDX_LAST) state_d = RF_IDLE;
        else                   idx_d   = idx_q + AW'(1);
      end
    endcase
  end

  // FSM state and sweep index registers.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= RF_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Register storage: WB writes while idle, one register zeroed per sweep cycle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end else if (swp_en) begin
      regs_q[idx_q] <= '0;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra;
    assign ra = raddr_i[k*AW +: AW];
    assign rdata_o[k*DW +: DW] = (ZERO_REG && (ra == '0))   ? '0      :
                                 (byp_en && (waddr_i == ra)) ? wdata_i :
                                                               regs_q[ra];
  end

  assign dbg_data_o = (ZERO_REG && (dbg_sel_i == '0)) ? '0 : regs_q[dbg_sel_i];

  rf_scoreboard #(
    .NREG     (NREG),
    .NRD      (NRD),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk        (clk),
    .clrn       (clrn),
    .set_en_i   (iss_valid_i && idle),
    .set_addr_i (iss_addr_i),
    .clr_en_i   (byp_en),
    .clr_addr_i (waddr_i),
    .clr_all_i  (clr_all),
    .raddr_i    (raddr_i),
    .rpend_o    (rpend_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_rf_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rf_bank
// Directed bench for rf_bank with a behavioural register/scoreboard/sweep
// model checked every cycle, plus hand-computed literal expectations.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rf_bank;

  localparam int DW   = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
  localparam bit ZR   = 1'b1;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  logic              we;
  logic [AW-1:0]     waddr;
  logic [DW-1:0]     wdata;
  logic [NRD*AW-1:0] raddr;
  logic              iss_valid;
  logic [AW-1:0]     iss_addr;
  logic              clr_req;
  logic [AW-1:0]     dbg_sel;

  logic [NRD*DW-1:0] rdata,    rdata_z0;
  logic [NRD-1:0]    rpend,    rpend_z0;
  logic              clr_busy, clr_busy_z0;
  logic [DW-1:0]     dbg_data, dbg_data_z0;

  int checks = 0;
  int errors = 0;

  rf_bank #(.DW(DW), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b1)) u_dut (
    .clk(clk), .clrn(clrn), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata), .rpend_o(rpend),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .clr_req_i(clr_req),
    .clr_busy_o(clr_busy), .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_data)
  );

  // Second instance with an ordinary r0, checked only on the r0 vectors.
  rf_bank #(.DW(DW), .NREG(NREG), .NRD(NRD), .ZERO_REG(1'b0)) u_dut_z0 (
    .clk(clk), .clrn(clrn), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .raddr_i(raddr), .rdata_o(rdata_z0), .rpend_o(rpend_z0),
    .iss_valid_i(iss_valid), .iss_addr_i(iss_addr), .clr_req_i(clr_req),
    .clr_busy_o(clr_busy_z0), .dbg_sel_i(dbg_sel), .dbg_data_o(dbg_data_z0)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    raddr[k*AW +: AW] = a;
  endtask

  // Behavioural model: register contents, pending flags, sweep cycles left.
  logic [DW-1:0] m_mem  [NREG];
  logic          m_pend [NREG];
  int            m_rem;

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < NREG; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
      m_rem = 0;
    end else if (m_rem != 0) begin
      m_mem[NREG - m_rem] = '0;
      m_rem = m_rem - 1;
    end else begin
      if (we && !(ZR && waddr == 0)) m_mem[waddr] = wdata;
      if (clr_req) begin
        for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
        m_rem = NREG - int'(ZR);
      end else begin
        if (we) m_pend[waddr] = 1'b0;
        if (iss_valid && !(ZR && iss_addr == 0)) m_pend[iss_addr] = 1'b1;
      end
    end
  end

  // Every-cycle comparison of the main instance against the model.
  always @(negedge clk) begin
    logic [AW-1:0] a;
    logic [DW-1:0] ed;
    logic          ep;
    logic          wb_hit;
    for (int k = 0; k < NRD; k++) begin
      a      = raddr[k*AW +: AW];
      wb_hit = we && (m_rem == 0) && (waddr == a);
      if (ZR && a == 0) begin
        ed = '0;
        ep = 1'b0;
      end else begin
        ed = wb_hit ? wdata : m_mem[a];
        ep = m_pend[a] && !wb_hit;
      end
      chk($sformatf("model rdata%0d", k), rdata[k*DW +: DW], ed);
      chk($sformatf("model rpend%0d", k), rpend[k], ep);
    end
    chk("model clr_busy", clr_busy, m_rem != 0);
    chk("model dbg_data", dbg_data, (ZR && dbg_sel == 0) ? '0 : m_mem[dbg_sel]);
  end

  initial begin
    int n;
    clrn = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    iss_valid = 1'b0; iss_addr = '0; clr_req = 1'b0; dbg_sel = '0;
    #1 clrn = 1'b0;
    #10;
    raddr = {5'd9, 5'd3}; dbg_sel = 5'd12;
    #1;
    chk("reset rdata", rdata, 0);
    chk("reset rpend", rpend, 0);
    chk("reset clr_busy", clr_busy, 0);
    chk("reset dbg_data", dbg_data, 0);
    clrn = 1'b1;

    // Plain write then read.
    tick(); we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    tick(); we = 1'b0; set_rd(0, 5'd5); #1;
    chk("read r5", rdata[DW-1:0], 32'hDEADBEEF);

    // Same-cycle bypass; debug port shows stored value only.
    tick(); we = 1'b1; waddr = 5'd7; wdata = 32'h12345678; set_rd(1, 5'd7); dbg_sel = 5'd7; #1;
    chk("bypass rdata1", rdata[2*DW-1:DW], 32'h12345678);
    chk("dbg before edge", dbg_data, 0);
    tick(); we = 1'b0; #1;
    chk("dbg after edge", dbg_data, 32'h12345678);

    // r0 behaviour with and without the hardwired zero.
    tick(); we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; iss_valid = 1'b1; iss_addr = 5'd0; set_rd(0, 5'd0); #1;
    chk("r0 zr bypass", rdata[DW-1:0], 0);
    chk("r0 plain bypass", rdata_z0[DW-1:0], 32'hFFFFFFFF);
    tick(); we = 1'b0; iss_valid = 1'b0; #1;
    chk("r0 zr read", rdata[DW-1:0], 0);
    chk("r0 zr rpend", rpend[0], 0);
    chk("r0 plain read", rdata_z0[DW-1:0], 32'hFFFFFFFF);
    chk("r0 plain set wins", rpend_z0[0], 1);

    // Scoreboard set, clear-by-writeback, same-edge set wins.
    tick(); iss_valid = 1'b1; iss_addr = 5'd3; set_rd(0, 5'd3); #1;
    chk("sb before set", rpend[0], 0);
    tick(); iss_valid = 1'b0; #1;
    chk("sb set", rpend[0], 1);
    tick(); we = 1'b1; waddr = 5'd3; wdata = 32'h33; #1;
    chk("sb wb same cycle", rpend[0], 0);
    chk("sb wb bypass data", rdata[DW-1:0], 32'h33);
    tick(); we = 1'b0; #1;
    chk("sb cleared", rpend[0], 0);
    tick(); we = 1'b1; waddr = 5'd3; wdata = 32'h44; iss_valid = 1'b1; iss_addr = 5'd3;
    tick(); we = 1'b0; iss_valid = 1'b0; #1;
    chk("sb set beats clear", rpend[0], 1);
    chk("sb data r3", rdata[DW-1:0], 32'h44);

    // Sweep: preload, mark r2 pending, then clear.
    for (int i = 1; i < NREG; i++) begin
      tick(); we = 1'b1; waddr = AW'(i); wdata = DW'(i);
    end
    tick(); we = 1'b0; iss_valid = 1'b1; iss_addr = 5'd2; set_rd(1, 5'd2);
    tick(); iss_valid = 1'b0; #1;
    chk("pre-sweep pend r2", rpend[1], 1);
    clr_req = 1'b1;
    tick(); clr_req = 1'b0;
    n = 0;
    while (clr_busy && n < 100) begin
      if (n == 0) chk("sweep pend cleared", rpend[1], 0);
      if (n == 3) begin
        we = 1'b1; waddr = 5'd9; wdata = 32'hAA; set_rd(0, 5'd9); #1;
        chk("sweep no bypass", rdata[DW-1:0], 32'd9);
      end
      if (n == 4) we = 1'b0;
      if (n == 5) clr_req = 1'b1;
      if (n == 6) clr_req = 1'b0;
      n++;
      tick();
    end
    chk("sweep length", n, 31);
    clr_req = 1'b0; we = 1'b0;
    dbg_sel = 5'd9; #1;
    chk("sweep dropped write r9", dbg_data, 0);
    for (int i = 0; i < NREG; i++) begin
      dbg_sel = AW'(i); raddr = {AW'(i), AW'(i)}; #1;
      chk($sformatf("post-sweep r%0d", i), dbg_data, 0);
      chk($sformatf("post-sweep rpend r%0d", i), rpend, 0);
    end

    // Reset in the middle of a sweep.
    tick(); we = 1'b1; waddr = 5'd20; wdata = 32'h20;
    tick(); we = 1'b0; clr_req = 1'b1;
    tick(); clr_req = 1'b0;
    repeat (9) tick();
    dbg_sel = 5'd20; #1;
    chk("mid-sweep busy", clr_busy, 1);
    chk("mid-sweep r20 intact", dbg_data, 32'h20);
    clrn = 1'b0; #1;
    chk("reset drops busy", clr_busy, 0);
    chk("reset clears r20", dbg_data, 0);
    clrn = 1'b1;
    we = 1'b1; waddr = 5'd6; wdata = 32'h66;
    tick(); we = 1'b0; dbg_sel = 5'd6; #1;
    chk("write after reset", dbg_data, 32'h66);
    chk("idle after reset", clr_busy, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
